// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_stage_reg: FSM state encoding, default widths
// and the control-bundle widths of each pipeline boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int PIPE_PC_W   = 32;
  localparam int PIPE_CTRL_W = 32;
  localparam int PIPE_DATA_W = 128;

  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_CTRL_W  = 24;
  localparam int EXMEM_CTRL_W = 12;
  localparam int MEMWB_CTRL_W = 6;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry (valid, pc, ctrl, data). clr beats load beats drop; with none of them
// asserted the entry is frozen bit-for-bit. clr always zeroes ctrl, pc/data only if ZERO_DATA_ON_FLUSH.
module pipe_slot #(
  parameter int PC_W               = 32,
  parameter int CTRL_W             = 32,
  parameter int DATA_W             = 128,
  parameter int ZERO_DATA_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              drop,
  input  logic [PC_W-1:0]   ld_pc,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              vld,
  output logic [PC_W-1:0]   pc,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      pc   <= '0;
      ctrl <= '0;
      data <= '0;
    end else if (clr) begin
      vld  <= 1'b0;
      ctrl <= '0;
      if (ZERO_DATA_ON_FLUSH != 0) begin
        pc   <= '0;
        data <= '0;
      end
    end else if (load) begin
      vld  <= 1'b1;
      pc   <= ld_pc;
      ctrl <= ld_ctrl;
      data <= ld_data;
    end else if (drop) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with 2-entry skid (1-cycle latency, registered in_ready), hold and flush.
// Optional perf counters enabled by `define PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_W               = PIPE_PC_W,
  parameter int CTRL_W             = PIPE_CTRL_W,
  parameter int DATA_W             = PIPE_DATA_W,
  parameter int ZERO_DATA_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_flush_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  state_t state_q, state_d;
  logic   in_ready_q;
  logic   in_fire, out_fire;
  logic   main_load, main_from_skid, main_drop, skid_load, skid_drop;

  logic [PC_W-1:0]   skid_pc, main_ld_pc;
  logic [CTRL_W-1:0] skid_ctrl, main_ld_ctrl;
  logic [DATA_W-1:0] skid_data, main_ld_data;
  logic              skid_vld_unused;

  assign in_ready = in_ready_q;
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready & ~hold;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          main_load = 1'b1;
          state_d   = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_drop = 1'b1;
            state_d   = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
          state_d        = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign main_ld_pc   = main_from_skid ? skid_pc   : in_pc;
  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_ld_data = main_from_skid ? skid_data : in_data;

  pipe_slot #(
    .PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_DATA_ON_FLUSH(ZERO_DATA_ON_FLUSH)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .clr(flush), .load(main_load), .drop(main_drop),
    .ld_pc(main_ld_pc), .ld_ctrl(main_ld_ctrl), .ld_data(main_ld_data),
    .vld(out_valid), .pc(out_pc), .ctrl(out_ctrl), .data(out_data)
  );

  // Skid occupancy is already encoded by state FULL, so its valid bit is not consumed.
  pipe_slot #(
    .PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_DATA_ON_FLUSH(ZERO_DATA_ON_FLUSH)
  ) u_skid (
    .clk(clk), .rst_n(rst_n), .clr(flush), .load(skid_load), .drop(skid_drop),
    .ld_pc(in_pc), .ld_ctrl(in_ctrl), .ld_data(in_data),
    .vld(skid_vld_unused), .pc(skid_pc), .ctrl(skid_ctrl), .data(skid_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (out_valid && (hold || !out_ready)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!out_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (flush && (state_q != EMPTY)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random stimulus for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;

  localparam int PC_W   = 32;
  localparam int CTRL_W = 32;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush, hold, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [PC_W-1:0]   in_pc, out_pc;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt;
  int unsigned m_stall, m_bubble, m_flush;
`endif

  pipe_stage_reg #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ZERO_DATA_ON_FLUSH(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
    .out_data(out_data), .perf_stall_cnt(perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
    .out_data(out_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t q[$];
  bit    m_rdy;
  bit    ctrl_zero;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy     = 1'b1;
    ctrl_zero = 1'b1;
`ifdef PIPE_STAGE_PERF_EN
    m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
  endtask

  task automatic drive(input bit v, input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl);
    in_valid = v;
    in_pc    = pc;
    in_ctrl  = ctrl;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic compare();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, m_rdy);
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_ctrl", out_ctrl, q[0].ctrl);
      chk("out_data", out_data, q[0].data);
    end else if (ctrl_zero) begin
      chk("bubble_ctrl", out_ctrl, 0);
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_stall);
    chk("perf_bubble", perf_bubble_cnt, m_bubble);
    chk("perf_flush", perf_flush_cnt, m_flush);
`endif
  endtask

  // Advance one clock: decide transfers from pre-edge inputs, update the model, compare after the edge.
  task automatic step();
    bit inf, outf;
    inf  = in_valid && m_rdy;
    outf = (q.size() > 0) && out_ready && !hold;
`ifdef PIPE_STAGE_PERF_EN
    if (q.size() > 0 && (hold || !out_ready)) m_stall++;
    if (q.size() == 0) m_bubble++;
    if (flush && q.size() > 0) m_flush++;
`endif
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
      ctrl_zero = 1'b1;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({in_pc, in_ctrl, in_data});
    end
    m_rdy = (q.size() < 2);
    if (q.size() > 0) ctrl_zero = 1'b0;
    compare();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    compare();

    // Streaming: one beat per cycle, output one cycle behind input.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, PC_W'(i * 4), $urandom);
      step();
      chk("stream_pc", out_pc, i * 4);
      chk("stream_in_ready", in_ready, 1);
    end
    drive(1'b0, '0, '0);
    step();

    // Hold in BUSY lets one more beat into the skid slot.
    drive(1'b1, 32'h10, $urandom);
    step();
    hold = 1'b1;
    drive(1'b1, 32'h14, $urandom);
    step();
    chk("hold_in_ready", in_ready, 0);
    chk("hold_pc", out_pc, 32'h10);
    drive(1'b0, '0, '0);
    step();
    step();
    chk("hold_pc_kept", out_pc, 32'h10);
    hold = 1'b0;
    step();
    chk("after_hold_pc", out_pc, 32'h14);
    step();
    chk("after_hold_empty", out_valid, 0);

    // Flush while FULL with all-ones control.
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hFFFF_FFFF);
    step();
    drive(1'b1, 32'h104, 32'hFFFF_FFFF);
    step();
    chk("full_in_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 32'h108, 32'hFFFF_FFFF);
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("flush_no_leak", out_valid, 0);

    // Flush in BUSY discards a beat that fires in the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 32'h200, $urandom);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h204, $urandom);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    step();
    chk("flush_fire_dropped", out_valid, 0);

    // flush and hold together: flush wins.
    drive(1'b1, 32'h300, $urandom);
    step();
    hold = 1'b1; flush = 1'b1;
    drive(1'b0, '0, '0);
    step();
    hold = 1'b0; flush = 1'b0;
    chk("flush_hold_valid", out_valid, 0);
    chk("flush_hold_in_ready", in_ready, 1);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 32'h400, $urandom);
    step();
    drive(1'b1, 32'h404, $urandom);
    step();
    drive(1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_out_data", out_data, 0);
    #4 rst_n = 1'b1;
    step();

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom);
      out_ready = $urandom_range(0, 9) < 7;
      hold      = $urandom_range(0, 9) < 2;
      flush     = $urandom_range(0, 99) < 3;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
